// File: rtl/receptor_pkg.sv
// Shared definitions for the receptor: symbol classes, framing states, lane count
// and the byte classifier used by the top level.
package receptor_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [3:0] {
    CLS_DATA = 4'd0,
    CLS_COM  = 4'd1,
    CLS_SKP  = 4'd2,
    CLS_STP  = 4'd3,
    CLS_SDP  = 4'd4,
    CLS_END  = 4'd5,
    CLS_EDB  = 4'd6,
    CLS_FTS  = 4'd7,
    CLS_IDLE = 4'd8
  } cls_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] com;
    logic [7:0] skp;
    logic [7:0] stp;
    logic [7:0] sdp;
    logic [7:0] end_ok;
    logic [7:0] edb;
    logic [7:0] fts;
    logic [7:0] idle;
  } codes_t;

  // The if-chain order is the tie-break when two code inputs hold the same value.
  function automatic cls_e classify(input logic [7:0] b, input codes_t c);
    if (b == c.com)         return CLS_COM;
    else if (b == c.skp)    return CLS_SKP;
    else if (b == c.stp)    return CLS_STP;
    else if (b == c.sdp)    return CLS_SDP;
    else if (b == c.end_ok) return CLS_END;
    else if (b == c.edb)    return CLS_EDB;
    else if (b == c.fts)    return CLS_FTS;
    else if (b == c.idle)   return CLS_IDLE;
    else                    return CLS_DATA;
  endfunction

endpackage

// File: rtl/receptor_byte_unstriping.sv
// Four-lane word buffer and serializer: captures a lane word and presents one
// byte per enabled cycle, lane0 first, accepting the next word while lane3 goes out.
module byte_unstriping
  import receptor_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic [NUM_LANES-1:0][7:0] lanes,
  input  logic                      rx_ValidE,
  output logic                      rx_ready,
  output logic [7:0]                byte_out,
  output logic                      byte_go,
  output logic                      overflow
);

  localparam int               CW   = $clog2(NUM_LANES);
  localparam logic [CW-1:0]    LAST = CW'(NUM_LANES - 1);

  logic [NUM_LANES-1:0][7:0] buf_q;
  logic [CW-1:0]             cnt_q;
  logic                      full_q;
  logic                      armed_q;
  logic                      accept;

  // armed_q keeps rx_ready low during reset and until the first enabled edge.
  assign rx_ready = enb && armed_q && (!full_q || cnt_q == LAST);
  assign accept   = rx_ready && rx_ValidE;
  assign overflow = enb && rx_ValidE && !rx_ready;
  assign byte_go  = enb && full_q;
  assign byte_out = buf_q[cnt_q];

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the buffer sits in the reset branch because a reset must discard a
    // half-sent word; storage that needs no reset value would be left out of it.
    if (!rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      armed_q <= 1'b0;
    end else if (enb) begin
      armed_q <= 1'b1;
      if (byte_go) begin
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == LAST) full_q <= 1'b0;
      end
      // NOTE: non-blocking updates let a capture on the lane3 edge override the
      // empty marking above; the last assignment in program order wins.
      if (accept) begin
        buf_q  <= lanes;
        full_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/receptor.sv
// Lane-word receiver: unstripes four lanes, classifies each byte and tracks
// packet framing. Define RX_SKP_FILTER_EN to suppress skp bytes from the output.
module receptor
  import receptor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [7:0] rx_lane0,
  input  logic [7:0] rx_lane1,
  input  logic [7:0] rx_lane2,
  input  logic [7:0] rx_lane3,
  input  logic       rx_ValidE,
  output logic       rx_ready,
  input  logic [7:0] com,
  input  logic [7:0] skp,
  input  logic [7:0] stp,
  input  logic [7:0] sdp,
  input  logic [7:0] end_ok,
  input  logic [7:0] edb,
  input  logic [7:0] fts,
  input  logic [7:0] idle,
  output logic [7:0] rx_DataS,
  output logic       rx_ValidS,
  output logic [3:0] rx_control_dk,
  output logic       rx_in_packet,
  output logic       rx_err
);

`ifdef RX_SKP_FILTER_EN
  localparam logic SKP_VISIBLE = 1'b0;
`else
  localparam logic SKP_VISIBLE = 1'b1;
`endif

  codes_t     codes;
  logic [7:0] byte_out;
  logic       byte_go;
  logic       overflow;
  cls_e       cls;
  state_e     state_q, state_n;
  logic       valid_n, err_n;

  assign codes = '{com, skp, stp, sdp, end_ok, edb, fts, idle};

  byte_unstriping u_unstripe (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .lanes     ({rx_lane3, rx_lane2, rx_lane1, rx_lane0}),
    .rx_ValidE (rx_ValidE),
    .rx_ready  (rx_ready),
    .byte_out  (byte_out),
    .byte_go   (byte_go),
    .overflow  (overflow)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cls     = classify(byte_out, codes);
    valid_n = 1'b1;
    err_n   = 1'b0;
    state_n = state_q;
    case (cls)
      CLS_DATA: begin
        valid_n = (state_q == ST_PKT);
        err_n   = (state_q == ST_IDLE);
      end
      CLS_SKP: valid_n = SKP_VISIBLE;
      CLS_STP, CLS_SDP: begin
        err_n   = (state_q == ST_PKT);
        state_n = ST_PKT;
      end
      CLS_END, CLS_EDB: begin
        err_n   = (state_q == ST_IDLE);
        state_n = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      rx_DataS      <= '0;
      rx_control_dk <= '0;
      rx_ValidS     <= 1'b0;
      rx_err        <= 1'b0;
    end else if (!enb) begin
      rx_ValidS <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_ValidS <= 1'b0;
      rx_err    <= overflow;
      if (byte_go) begin
        rx_DataS      <= byte_out;
        rx_control_dk <= cls;
        rx_ValidS     <= valid_n;
        rx_err        <= err_n || overflow;
        state_q       <= state_n;
      end
    end
  end

  assign rx_in_packet = (state_q == ST_PKT);

endmodule

// File: tb/tb_receptor.sv
// Directed bench for receptor: expected per-cycle outputs are queued as words
// are driven and popped one per clock edge.
module tb_receptor;

  logic       clk = 1'b0;
  logic       rst, enb, rx_ValidE;
  logic [7:0] rx_lane0, rx_lane1, rx_lane2, rx_lane3;
  logic [7:0] com, skp, stp, sdp, end_ok, edb, fts, idle;
  logic       rx_ready, rx_ValidS, rx_in_packet, rx_err;
  logic [7:0] rx_DataS;
  logic [3:0] rx_control_dk;

  always #5 clk = ~clk;

  receptor dut (
    .clk(clk), .rst(rst), .enb(enb),
    .rx_lane0(rx_lane0), .rx_lane1(rx_lane1), .rx_lane2(rx_lane2), .rx_lane3(rx_lane3),
    .rx_ValidE(rx_ValidE), .rx_ready(rx_ready),
    .com(com), .skp(skp), .stp(stp), .sdp(sdp), .end_ok(end_ok), .edb(edb),
    .fts(fts), .idle(idle),
    .rx_DataS(rx_DataS), .rx_ValidS(rx_ValidS), .rx_control_dk(rx_control_dk),
    .rx_in_packet(rx_in_packet), .rx_err(rx_err)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [3:0] cls;
    logic       pkt;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic cur_pkt = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [7:0] d, input logic [3:0] c,
                      input logic p, input logic e);
    exp_t x;
    x = '{v, d, c, p, e};
    sb.push_back(x);
  endtask

  // A word captured into an empty buffer produces nothing on its capture edge.
  task automatic drive_word(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    if (sb.size() == 0) push(1'b0, 8'h00, 4'h0, cur_pkt, 1'b0);
    rx_lane0  = b0;
    rx_lane1  = b1;
    rx_lane2  = b2;
    rx_lane3  = b3;
    rx_ValidE = 1'b1;
  endtask

  task automatic tick(input logic ovf);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{1'b0, 8'h00, 4'h0, cur_pkt, 1'b0};
    e.err   = e.err | ovf;
    cur_pkt = e.pkt;
    check("valid_s", 32'(rx_ValidS), 32'(e.valid));
    check("err", 32'(rx_err), 32'(e.err));
    check("in_packet", 32'(rx_in_packet), 32'(e.pkt));
    if (e.valid) begin
      check("data_s", 32'(rx_DataS), 32'(e.data));
      check("control_dk", 32'(rx_control_dk), 32'(e.cls));
    end
  endtask

  task automatic hold_tick();
    @(posedge clk);
    #1;
    check("stall_valid_s", 32'(rx_ValidS), 32'd0);
    check("stall_err", 32'(rx_err), 32'd0);
    check("stall_in_packet", 32'(rx_in_packet), 32'(cur_pkt));
    check("stall_ready", 32'(rx_ready), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_s"}, 32'(rx_DataS), 32'd0);
    check({tag, "_control_dk"}, 32'(rx_control_dk), 32'd0);
    check({tag, "_valid_s"}, 32'(rx_ValidS), 32'd0);
    check({tag, "_in_packet"}, 32'(rx_in_packet), 32'd0);
    check({tag, "_err"}, 32'(rx_err), 32'd0);
    check({tag, "_ready"}, 32'(rx_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b0; enb = 1'b1; rx_ValidE = 1'b0;
    rx_lane0 = '0; rx_lane1 = '0; rx_lane2 = '0; rx_lane3 = '0;
    com = 8'hBC; skp = 8'h1C; stp = 8'hFB; sdp = 8'h5C;
    end_ok = 8'hFD; edb = 8'hFE; fts = 8'h3C; idle = 8'h7C;

    #12;
    check_all_zero("in_reset");
    rst = 1'b1;
    tick(1'b0);
    check("ready_after_reset", 32'(rx_ready), 32'd1);

    // Packet across two back-to-back words
    drive_word(8'hFB, 8'h11, 8'h22, 8'h33);
    push(1, 8'hFB, 3, 1, 0); push(1, 8'h11, 0, 1, 0);
    push(1, 8'h22, 0, 1, 0); push(1, 8'h33, 0, 1, 0);
    tick(1'b0);
    rx_ValidE = 1'b0;
    check("ready_busy", 32'(rx_ready), 32'd0);
    repeat (3) tick(1'b0);
    check("ready_last_lane", 32'(rx_ready), 32'd1);
    drive_word(8'h44, 8'hFD, 8'h7C, 8'h7C);
    push(1, 8'h44, 0, 1, 0); push(1, 8'hFD, 5, 0, 0);
    push(1, 8'h7C, 8, 0, 0); push(1, 8'h7C, 8, 0, 0);
    tick(1'b0);
    rx_ValidE = 1'b0;
    repeat (5) tick(1'b0);

    // Stray data in IDLE
    drive_word(8'hAA, 8'hBB, 8'h7C, 8'h7C);
    push(0, 8'hAA, 0, 0, 1); push(0, 8'hBB, 0, 0, 1);
    push(1, 8'h7C, 8, 0, 0); push(1, 8'h7C, 8, 0, 0);
    tick(1'b0);
    rx_ValidE = 1'b0;
    repeat (5) tick(1'b0);

    // Framing errors: sdp inside a packet, edb outside one
    drive_word(8'hBC, 8'h3C, 8'hFB, 8'h5C);
    push(1, 8'hBC, 1, 0, 0); push(1, 8'h3C, 7, 0, 0);
    push(1, 8'hFB, 3, 1, 0); push(1, 8'h5C, 4, 1, 1);
    tick(1'b0);
    rx_ValidE = 1'b0;
    repeat (3) tick(1'b0);
    drive_word(8'hFD, 8'hFE, 8'h7C, 8'h7C);
    push(1, 8'hFD, 5, 0, 0); push(1, 8'hFE, 6, 0, 1);
    push(1, 8'h7C, 8, 0, 0); push(1, 8'h7C, 8, 0, 0);
    tick(1'b0);
    rx_ValidE = 1'b0;
    repeat (5) tick(1'b0);

    // Classification priority: com wins over fts when both codes match
    fts = 8'hBC;
    drive_word(8'hBC, 8'hBC, 8'hBC, 8'hBC);
    repeat (4) push(1, 8'hBC, 1, 0, 0);
    tick(1'b0);
    rx_ValidE = 1'b0;
    repeat (5) tick(1'b0);
    fts = 8'h3C;

    // Overflow: rx_ValidE held high, accepted only every fourth cycle
    drive_word(8'h7C, 8'h7C, 8'h7C, 8'h7C);
    repeat (4) push(1, 8'h7C, 8, 0, 0);
    check("ovf_ready_c0", 32'(rx_ready), 32'd1);
    tick(1'b0);
    repeat (3) begin
      check("ovf_ready_busy", 32'(rx_ready), 32'd0);
      tick(1'b1);
    end
    check("ovf_ready_c4", 32'(rx_ready), 32'd1);
    repeat (4) push(1, 8'h7C, 8, 0, 0);
    tick(1'b0);
    repeat (3) begin
      check("ovf_ready_busy", 32'(rx_ready), 32'd0);
      tick(1'b1);
    end
    check("ovf_ready_c8", 32'(rx_ready), 32'd1);
    repeat (4) push(1, 8'h7C, 8, 0, 0);
    tick(1'b0);
    rx_ValidE = 1'b0;
    repeat (5) tick(1'b0);

    // skp handling
    drive_word(8'h1C, 8'h1C, 8'h1C, 8'h1C);
`ifdef RX_SKP_FILTER_EN
    repeat (4) push(0, 8'h1C, 2, 0, 0);
`else
    repeat (4) push(1, 8'h1C, 2, 0, 0);
`endif
    tick(1'b0);
    rx_ValidE = 1'b0;
    repeat (5) tick(1'b0);

    // Reset after lane1 of a packet word has been emitted
    drive_word(8'hFB, 8'h11, 8'h22, 8'h33);
    push(1, 8'hFB, 3, 1, 0); push(1, 8'h11, 0, 1, 0);
    push(1, 8'h22, 0, 1, 0); push(1, 8'h33, 0, 1, 0);
    tick(1'b0);
    rx_ValidE = 1'b0;
    repeat (2) tick(1'b0);
    #1 rst = 1'b0;
    #1 check_all_zero("mid_reset");
    sb.delete();
    cur_pkt = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (5) tick(1'b0);
    check("data_after_reset", 32'(rx_DataS), 32'd0);
    check("ready_after_rerelease", 32'(rx_ready), 32'd1);

    // enb stall in the middle of a word
    drive_word(8'hFB, 8'h01, 8'h02, 8'h03);
    push(1, 8'hFB, 3, 1, 0); push(1, 8'h01, 0, 1, 0);
    push(1, 8'h02, 0, 1, 0); push(1, 8'h03, 0, 1, 0);
    tick(1'b0);
    rx_ValidE = 1'b0;
    repeat (2) tick(1'b0);
    enb = 1'b0;
    repeat (3) hold_tick();
    enb = 1'b1;
    repeat (2) tick(1'b0);
    drive_word(8'hFD, 8'h7C, 8'h7C, 8'h7C);
    push(1, 8'hFD, 5, 0, 0);
    repeat (3) push(1, 8'h7C, 8, 0, 0);
    tick(1'b0);
    rx_ValidE = 1'b0;
    repeat (5) tick(1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
